// File: rtl/ram_bridge.sv
// Bridges the CPU 32-bit RAM port onto a 16-bit req/ack memory port, one beat per active half.
// Optional beat timeout/abort with sticky ERR is enabled by defining RAM_BRIDGE_TIMEOUT_EN.
module ram_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1023
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic        BCYSTn,
  input  logic [20:0] RAM_A,
  input  logic [31:0] RAM_DI,
  output logic [31:0] RAM_DO,
  input  logic        RAM_CEn,
  input  logic        RAM_WEn,
  input  logic [3:0]  RAM_BEn,
  output logic        RAM_READYn,
  output logic        MEM_REQ,
  input  logic        MEM_ACK,
  output logic        MEM_WE,
  output logic [19:0] MEM_A,
  output logic [15:0] MEM_DO,
  output logic [1:0]  MEM_BE,
  input  logic [15:0] MEM_DI,
  output logic        ERR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [18:0] addr_q;
  logic [31:0] di_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic [31:0] ram_do_q;
  logic        readyn_q;
  logic        req_q;
  logic        mem_we_q;
  logic [19:0] mem_a_q;
  logic [15:0] mem_do_q;
  logic [1:0]  mem_be_q;
  logic [3:0]  be_d;
  logic        unused_s;

  assign be_d = ~RAM_BEn;

`ifdef RAM_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             tmo_s;

  // A beat has waited its full budget when the counter hits the last allowed cycle
  assign tmo_s    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 32'd1));
  assign ERR      = err_q;
  assign unused_s = ^RAM_A[1:0];
`else
  assign ERR      = 1'b0;
  assign unused_s = ^{RAM_A[1:0], TIMEOUT_CYCLES[0]};
`endif

  // Access sequencer: latches the CPU request, issues the beats and handshakes READYn
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state_q  <= IDLE;
      addr_q   <= 19'd0;
      di_q     <= 32'd0;
      be_q     <= 4'd0;
      we_q     <= 1'b0;
      ram_do_q <= 32'd0;
      readyn_q <= 1'b1;
      req_q    <= 1'b0;
      mem_we_q <= 1'b0;
      mem_a_q  <= 20'd0;
      mem_do_q <= 16'd0;
      mem_be_q <= 2'd0;
`ifdef RAM_BRIDGE_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (CE && !BCYSTn && !RAM_CEn) begin
            addr_q   <= RAM_A[20:2];
            di_q     <= RAM_DI;
            be_q     <= be_d;
            we_q     <= ~RAM_WEn;
            mem_we_q <= ~RAM_WEn;
            ram_do_q <= 32'd0;
`ifdef RAM_BRIDGE_TIMEOUT_EN
            cnt_q    <= '0;
`endif
            if (be_d[1:0] != 2'b00) begin
              state_q  <= LO;
              req_q    <= 1'b1;
              mem_a_q  <= {RAM_A[20:2], 1'b0};
              mem_be_q <= be_d[1:0];
              mem_do_q <= RAM_DI[15:0];
            end else if (be_d[3:2] != 2'b00) begin
              state_q  <= HI;
              req_q    <= 1'b1;
              mem_a_q  <= {RAM_A[20:2], 1'b1};
              mem_be_q <= be_d[3:2];
              mem_do_q <= RAM_DI[31:16];
            end else begin
              state_q  <= DONE;
              readyn_q <= 1'b0;
            end
          end
        end
        LO: begin
          if (req_q && MEM_ACK) begin
            req_q <= 1'b0;
            if (!we_q) begin
              ram_do_q[15:0] <= MEM_DI;
            end
            // The high beat is staged now but its request waits one cycle in HI
            if (be_q[3:2] != 2'b00) begin
              state_q  <= HI;
              mem_a_q  <= {addr_q, 1'b1};
              mem_be_q <= be_q[3:2];
              mem_do_q <= di_q[31:16];
            end else begin
              state_q  <= DONE;
              readyn_q <= 1'b0;
            end
`ifdef RAM_BRIDGE_TIMEOUT_EN
          end else if (req_q) begin
            if (tmo_s) begin
              req_q          <= 1'b0;
              ram_do_q[15:0] <= 16'hFFFF;
              err_q          <= 1'b1;
              state_q        <= DONE;
              readyn_q       <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
`endif
          end
        end
        HI: begin
          if (!req_q) begin
            req_q <= 1'b1;
`ifdef RAM_BRIDGE_TIMEOUT_EN
            cnt_q <= '0;
`endif
          end else if (MEM_ACK) begin
            req_q    <= 1'b0;
            state_q  <= DONE;
            readyn_q <= 1'b0;
            if (!we_q) begin
              ram_do_q[31:16] <= MEM_DI;
            end
`ifdef RAM_BRIDGE_TIMEOUT_EN
          end else if (tmo_s) begin
            req_q           <= 1'b0;
            ram_do_q[31:16] <= 16'hFFFF;
            err_q           <= 1'b1;
            state_q         <= DONE;
            readyn_q        <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
`endif
          end
        end
        DONE: begin
          // A deselected chip releases the handshake without waiting for the CPU sample
          if (RAM_CEn || CE) begin
            state_q  <= IDLE;
            readyn_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          req_q    <= 1'b0;
          readyn_q <= 1'b1;
        end
      endcase
    end
  end

  assign RAM_DO     = ram_do_q;
  assign RAM_READYn = readyn_q;
  assign MEM_REQ    = req_q;
  assign MEM_WE     = mem_we_q;
  assign MEM_A      = mem_a_q;
  assign MEM_DO     = mem_do_q;
  assign MEM_BE     = mem_be_q;

endmodule

// File: tb/tb_ram_bridge.sv
// Directed self-checking bench for ram_bridge; the timeout case is built only with RAM_BRIDGE_TIMEOUT_EN.
module tb_ram_bridge;

  logic        CLK;
  logic        RESn;
  logic        CE;
  logic        BCYSTn;
  logic [20:0] RAM_A;
  logic [31:0] RAM_DI;
  logic [31:0] RAM_DO;
  logic        RAM_CEn;
  logic        RAM_WEn;
  logic [3:0]  RAM_BEn;
  logic        RAM_READYn;
  logic        MEM_REQ;
  logic        MEM_ACK;
  logic        MEM_WE;
  logic [19:0] MEM_A;
  logic [15:0] MEM_DO;
  logic [1:0]  MEM_BE;
  logic [15:0] MEM_DI;
  logic        ERR;

  int tests_run;
  int tests_failed;

  ram_bridge #(.TIMEOUT_CYCLES(32'd8)) dut (
    .CLK(CLK), .RESn(RESn), .CE(CE), .BCYSTn(BCYSTn),
    .RAM_A(RAM_A), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO),
    .RAM_CEn(RAM_CEn), .RAM_WEn(RAM_WEn), .RAM_BEn(RAM_BEn),
    .RAM_READYn(RAM_READYn), .MEM_REQ(MEM_REQ), .MEM_ACK(MEM_ACK),
    .MEM_WE(MEM_WE), .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_BE(MEM_BE),
    .MEM_DI(MEM_DI), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_access(input logic [20:0] a, input logic [31:0] di,
                              input logic [3:0] ben, input logic wen);
    @(negedge CLK);
    RAM_A   = a;
    RAM_DI  = di;
    RAM_BEn = ben;
    RAM_WEn = wen;
    RAM_CEn = 1'b0;
    BCYSTn  = 1'b0;
    CE      = 1'b1;
    @(negedge CLK);
    BCYSTn  = 1'b1;
    CE      = 1'b0;
  endtask

  task automatic serve_beat(input string tag, input logic [19:0] exp_a, input logic [1:0] exp_be,
                            input logic exp_we, input logic [15:0] exp_do, input logic [15:0] rd);
    for (int i = 0; i < 16 && MEM_REQ !== 1'b1; i++) @(negedge CLK);
    check_val({tag, "_req"}, {31'd0, MEM_REQ}, 32'd1);
    check_val({tag, "_a"},   {12'd0, MEM_A}, {12'd0, exp_a});
    check_val({tag, "_be"},  {30'd0, MEM_BE}, {30'd0, exp_be});
    check_val({tag, "_we"},  {31'd0, MEM_WE}, {31'd0, exp_we});
    if (exp_we) check_val({tag, "_do"}, {16'd0, MEM_DO}, {16'd0, exp_do});
    MEM_ACK = 1'b1;
    MEM_DI  = rd;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    MEM_DI  = 16'h0000;
    check_val({tag, "_reqdrop"}, {31'd0, MEM_REQ}, 32'd0);
  endtask

  task automatic finish_access(input string tag);
    @(negedge CLK);
    check_val({tag, "_rdy_hold"}, {31'd0, RAM_READYn}, 32'd0);
    CE = 1'b1;
    @(negedge CLK);
    CE = 1'b0;
    check_val({tag, "_rdy_rel"}, {31'd0, RAM_READYn}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    RESn = 1'b0; CE = 1'b0; BCYSTn = 1'b1; RAM_A = 21'd0; RAM_DI = 32'd0;
    RAM_CEn = 1'b1; RAM_WEn = 1'b1; RAM_BEn = 4'hF; MEM_ACK = 1'b0; MEM_DI = 16'h0000;
    repeat (3) @(negedge CLK);
    check_val("rst_ready", {31'd0, RAM_READYn}, 32'd1);
    check_val("rst_do",    RAM_DO, 32'd0);
    check_val("rst_req",   {31'd0, MEM_REQ}, 32'd0);
    check_val("rst_mema",  {12'd0, MEM_A}, 32'd0);
    check_val("rst_err",   {31'd0, ERR}, 32'd0);
    RESn = 1'b1;

    // Strobe without CE must not start an access
    @(negedge CLK);
    RAM_CEn = 1'b0; RAM_BEn = 4'h0; BCYSTn = 1'b0; CE = 1'b0;
    @(negedge CLK);
    BCYSTn = 1'b1;
    check_val("noce_req", {31'd0, MEM_REQ}, 32'd0);

    // Two-beat read
    start_access(21'h000104, 32'h0, 4'b0000, 1'b1);
    serve_beat("rd2_lo", 20'h00082, 2'b11, 1'b0, 16'h0, 16'hBEEF);
    check_val("rd2_gap_rdy", {31'd0, RAM_READYn}, 32'd1);
    serve_beat("rd2_hi", 20'h00083, 2'b11, 1'b0, 16'h0, 16'hDEAD);
    check_val("rd2_rdy", {31'd0, RAM_READYn}, 32'd0);
    check_val("rd2_do",  RAM_DO, 32'hDEADBEEF);
    finish_access("rd2");
    check_val("rd2_do_hold", RAM_DO, 32'hDEADBEEF);

    // Low-half write only
    start_access(21'h000200, 32'h12345678, 4'b1100, 1'b0);
    serve_beat("wr_lo", 20'h00100, 2'b11, 1'b1, 16'h5678, 16'h0);
    check_val("wr_rdy", {31'd0, RAM_READYn}, 32'd0);
    repeat (2) @(negedge CLK);
    check_val("wr_no_hi", {31'd0, MEM_REQ}, 32'd0);
    check_val("wr_do", RAM_DO, 32'd0);
    CE = 1'b1;
    @(negedge CLK);
    CE = 1'b0;
    check_val("wr_rdy_rel", {31'd0, RAM_READYn}, 32'd1);

    // Byte 3 read only: single high beat
    start_access(21'h000300, 32'h0, 4'b0111, 1'b1);
    serve_beat("rdb3_hi", 20'h00181, 2'b10, 1'b0, 16'h0, 16'hAB00);
    check_val("rdb3_rdy", {31'd0, RAM_READYn}, 32'd0);
    check_val("rdb3_do",  RAM_DO, 32'hAB000000);
    finish_access("rdb3");

    // No bytes enabled: immediate completion, released by chip deselect
    start_access(21'h000400, 32'hFFFFFFFF, 4'b1111, 1'b1);
    check_val("nob_rdy", {31'd0, RAM_READYn}, 32'd0);
    check_val("nob_req", {31'd0, MEM_REQ}, 32'd0);
    check_val("nob_do",  RAM_DO, 32'd0);
    RAM_CEn = 1'b1;
    @(negedge CLK);
    check_val("nob_cen_rel", {31'd0, RAM_READYn}, 32'd1);

    // Reset in the middle of a beat
    start_access(21'h000040, 32'h0, 4'b0000, 1'b1);
    check_val("rstmid_req_pre", {31'd0, MEM_REQ}, 32'd1);
    #2 RESn = 1'b0;
    #1;
    check_val("rstmid_req", {31'd0, MEM_REQ}, 32'd0);
    check_val("rstmid_rdy", {31'd0, RAM_READYn}, 32'd1);
    @(negedge CLK);
    RESn = 1'b1; MEM_ACK = 1'b1; MEM_DI = 16'h5555;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    check_val("late_ack_req", {31'd0, MEM_REQ}, 32'd0);
    check_val("late_ack_rdy", {31'd0, RAM_READYn}, 32'd1);
    check_val("late_ack_do",  RAM_DO, 32'd0);
    start_access(21'h000010, 32'h0, 4'b0000, 1'b1);
    serve_beat("after_lo", 20'h00008, 2'b11, 1'b0, 16'h0, 16'h1111);
    serve_beat("after_hi", 20'h00009, 2'b11, 1'b0, 16'h0, 16'h2222);
    check_val("after_do", RAM_DO, 32'h22221111);
    finish_access("after");

`ifdef RAM_BRIDGE_TIMEOUT_EN
    // No acknowledge: beat aborts after eight cycles of request
    start_access(21'h000008, 32'h0, 4'b0000, 1'b1);
    repeat (7) @(negedge CLK);
    check_val("tmo_req_last", {31'd0, MEM_REQ}, 32'd1);
    @(negedge CLK);
    check_val("tmo_req", {31'd0, MEM_REQ}, 32'd0);
    check_val("tmo_rdy", {31'd0, RAM_READYn}, 32'd0);
    check_val("tmo_do",  RAM_DO, 32'h0000FFFF);
    check_val("tmo_err", {31'd0, ERR}, 32'd1);
    repeat (2) @(negedge CLK);
    check_val("tmo_no_hi", {31'd0, MEM_REQ}, 32'd0);
    CE = 1'b1;
    @(negedge CLK);
    CE = 1'b0;
    check_val("tmo_err_sticky", {31'd0, ERR}, 32'd1);
    RESn = 1'b0;
    @(negedge CLK);
    RESn = 1'b1;
    check_val("tmo_err_clr", {31'd0, ERR}, 32'd0);
`else
    check_val("err_tied", {31'd0, ERR}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ram_bridge.md
Name: ram_bridge

Overview:
Downstream consumer of the machine's 32-bit RAM port (RAM_A/DI/DO/CEn/WEn/BEn/READYn). Splits each CPU RAM access into at most two 16-bit beats on a req/ack memory port (SDRAM controller side), skipping halves whose byte enables are all inactive. Returns assembled read data and RAM_READYn. This lets the CPU wait states track real memory latency.

Parameters:
TIMEOUT_CYCLES, 1023, CLK cycles a beat may wait for MEM_ACK before abort (used only with RAM_BRIDGE_TIMEOUT_EN)

Ports:
CLK  in  1  core clock
RESn  in  1  asynchronous active-low reset
CE  in  1  CPU clock enable; the CPU samples RAM_READYn and RAM_DO on CLK edges with CE=1
BCYSTn  in  1  CPU bus-cycle start strobe, active low, qualified by CE
RAM_A  in  21  CPU byte address; bits [1:0] ignored
RAM_DI  in  32  CPU write data
RAM_DO  out  32  assembled read data
RAM_CEn  in  1  RAM chip enable, active low
RAM_WEn  in  1  write enable, active low
RAM_BEn  in  4  byte enables, active low, bit n = byte n
RAM_READYn  out  1  access complete, active low
MEM_REQ  out  1  beat request, level
MEM_ACK  in  1  beat acknowledge, 1-cycle pulse
MEM_WE  out  1  1=write beat
MEM_A  out  20  halfword address (byte address [20:1])
MEM_DO  out  16  write data for beat
MEM_BE  out  2  byte enables, active high
MEM_DI  in  16  read data, valid in MEM_ACK cycle
ERR  out  1  sticky timeout flag (constant 0 without the optional feature)

Behaviour:
- Reset (async) state and outputs: IDLE, RAM_READYn=1, RAM_DO=0, MEM_REQ=0, MEM_WE=0, MEM_A=0, MEM_DO=0, MEM_BE=0, ERR=0. Reset mid-beat drops MEM_REQ immediately; a late MEM_ACK after reset is ignored.
- States: IDLE, LO, HI, DONE.
- IDLE: on CLK edge with CE=1, BCYSTn=0, RAM_CEn=0: latch A[20:2], RAM_DI, ~RAM_BEn, ~RAM_WEn. Clear RAM_DO to 0. Go to LO if BE[1:0]!=0, else HI if BE[3:2]!=0, else DONE.
- LO: MEM_A={A[20:2],0}, MEM_BE=BE[1:0], MEM_DO=DI[15:0]. MEM_REQ rises on the state-entry edge. MEM_A/WE/DO/BE are stable while MEM_REQ=1.
- LO on MEM_ACK: MEM_REQ=0 at the same edge. Reads capture MEM_DI into RAM_DO[15:0]. Next state is HI if BE[3:2]!=0, else DONE.
- HI: as LO with MEM_A={A[20:2],1}, BE[3:2], DI[31:16], and capture into RAM_DO[31:16]. After ACK go to DONE.
- MEM_REQ is low for at least one CLK between consecutive beats. MEM_ACK while MEM_REQ=0 is ignored.
- Skipped halves read back as 16'h0000. Byte lanes inside a fetched half are returned as delivered by memory.
- DONE: RAM_READYn=0 (registered; first low on the DONE-entry edge). Exit to IDLE with RAM_READYn=1 on the first CLK edge with CE=1 (the CPU sample point). If RAM_CEn=1 while in DONE, go to IDLE regardless of CE.
- A new BCYSTn is accepted only in IDLE. Minimum latency: 2-beat access with immediate ACK gives READYn low 4 CLK after start; no-byte access gives 1 CLK.
- RAM_DO holds its value until the next access starts.

Optional Feature:
Macro RAM_BRIDGE_TIMEOUT_EN.
- With it: a per-beat counter counts CLK cycles with MEM_REQ=1 and no ACK. On reaching TIMEOUT_CYCLES the beat aborts: MEM_REQ drops, that half's RAM_DO reads 16'hFFFF, the remaining beat is skipped, state goes to DONE, and ERR is set until reset.
- Without it: no counter, ERR tied 0, and the bridge waits for MEM_ACK indefinitely.

Test Plan:
- Read, RAM_A=0x000104, BEn=4'b0000; ACK with MEM_DI=0xBEEF at A=0x00082, then 0xDEAD at 0x00083 -> RAM_DO=0xDEADBEEF, two REQs with a gap, READYn low until the next CE edge.
- Write, A=0x000200, BEn=4'b1100, DI=0x12345678 -> one beat: MEM_A=0x00100, MEM_WE=1, MEM_BE=2'b11, MEM_DO=0x5678; no HI beat.
- Read, BEn=4'b0111; ACK with MEM_DI=0xAB00 -> single HI beat with MEM_BE=2'b10; RAM_DO=0xAB000000.
- BEn=4'b1111 -> no MEM_REQ; READYn low 1 CLK after start; RAM_DO=0.
- RESn pulsed low during LO with MEM_REQ=1 -> MEM_REQ=0 and READYn=1 immediately; late ACK ignored; next access completes normally.
- With RAM_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ACK on a BEn=0000 read -> abort after 8 cycles, RAM_DO=0x0000FFFF, no HI beat, ERR=1 until reset.
